// File: rtl/status_led_pkg.sv
// Shared types and default timing for the status LED sequencer.
// The state enum always lists the flash states; they are only reachable with STATUS_LED_ACT_EN.
package status_led_pkg;

    localparam int FAULT_W = 4;

    localparam int DEF_CLK_HZ         = 50_000_000;
    localparam int DEF_TICK_HZ        = 100;
    localparam int DEF_HB_TICKS       = 50;
    localparam int DEF_CODE_ON_TICKS  = 20;
    localparam int DEF_CODE_OFF_TICKS = 30;
    localparam int DEF_CODE_GAP_TICKS = 150;
    localparam int DEF_FLASH_TICKS    = 5;

    typedef enum logic [2:0] {
        ST_HB        = 3'd0,
        ST_CODE_ON   = 3'd1,
        ST_CODE_OFF  = 3'd2,
        ST_CODE_GAP  = 3'd3,
        ST_FLASH_ON  = 3'd4,
        ST_FLASH_OFF = 3'd5
    } state_e;

    function automatic int max5(input int a, input int b, input int c, input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Timebase prescaler: counts 0..DIV-1 and flags the last count as a one-cycle tick.
// tick_nxt predicts next cycle's tick so registered outputs can line up with it.
module led_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick,
    output logic tick_nxt
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick     = (cnt_q == LAST);
    assign tick_nxt = (cnt_d == LAST);

endmodule

// File: rtl/status_led_ctrl.sv
// Status LED sequencer: fault blink codes over activity flash over idle heartbeat.
// Define STATUS_LED_ACT_EN to build in the activity flash (FLASH_ON/FLASH_OFF, act_pulse).
//   state     | meaning
//   HB        | idle heartbeat, led follows hb_level
//   CODE_ON   | lit part of one fault-code pulse
//   CODE_OFF  | dark time after a pulse
//   CODE_GAP  | dark gap after the last pulse, code_done on its final cycle
//   FLASH_ON  | activity flash lit
//   FLASH_OFF | activity flash dark
module status_led_ctrl
    import status_led_pkg::*;
#(
    parameter int CLK_HZ         = DEF_CLK_HZ,
    parameter int TICK_HZ        = DEF_TICK_HZ,
    parameter int HB_TICKS       = DEF_HB_TICKS,
    parameter int CODE_ON_TICKS  = DEF_CODE_ON_TICKS,
    parameter int CODE_OFF_TICKS = DEF_CODE_OFF_TICKS,
    parameter int CODE_GAP_TICKS = DEF_CODE_GAP_TICKS,
    parameter int FLASH_TICKS    = DEF_FLASH_TICKS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FAULT_W-1:0] fault_code,
    input  logic               act_pulse,
    output logic               led,
    output logic               busy,
    output logic               code_done
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int MAX_T = max5(HB_TICKS, CODE_ON_TICKS, CODE_OFF_TICKS, CODE_GAP_TICKS, FLASH_TICKS);
    localparam int PH_W  = $clog2(MAX_T + 1);

    localparam logic [PH_W-1:0] HB_TC  = PH_W'(HB_TICKS - 1);
    localparam logic [PH_W-1:0] ON_TC  = PH_W'(CODE_ON_TICKS - 1);
    localparam logic [PH_W-1:0] OFF_TC = PH_W'(CODE_OFF_TICKS - 1);
    localparam logic [PH_W-1:0] GAP_TC = PH_W'(CODE_GAP_TICKS - 1);
`ifdef STATUS_LED_ACT_EN
    localparam logic [PH_W-1:0] FL_TC  = PH_W'(FLASH_TICKS - 1);
`else
    logic unused_act;
    assign unused_act = act_pulse;
`endif

    state_e             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic               hb_q, hb_d;
    logic [FAULT_W-1:0] code_q, code_d;
    logic [FAULT_W-1:0] pcnt_q, pcnt_d;
    logic               led_q, led_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               restart;
    logic               clr;
    logic               tick;
    logic               tick_nxt;

    led_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .tick     (tick),
        .tick_nxt (tick_nxt)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hb_d    = hb_q;
        code_d  = code_q;
        pcnt_d  = pcnt_q;
        restart = 1'b0;
        if (tick) begin
            phase_d = phase_q + 1'b1;
        end

        case (state_q)
            ST_HB: begin
                if (fault_code != '0) begin
                    code_d  = fault_code;
                    pcnt_d  = '0;
                    state_d = ST_CODE_ON;
                end
`ifdef STATUS_LED_ACT_EN
                else if (act_pulse) begin
                    state_d = ST_FLASH_ON;
                end
`endif
                else if (tick && (phase_q == HB_TC)) begin
                    hb_d    = ~hb_q;
                    phase_d = '0;
                end
            end
            ST_CODE_ON: begin
                if (tick && (phase_q == ON_TC)) begin
                    state_d = ST_CODE_OFF;
                    pcnt_d  = pcnt_q + 1'b1;
                end
            end
            ST_CODE_OFF: begin
                if (tick && (phase_q == OFF_TC)) begin
                    state_d = (pcnt_q == code_q) ? ST_CODE_GAP : ST_CODE_ON;
                end
            end
            ST_CODE_GAP: begin
                // fault_code is only looked at here, so a running code is never cut short
                if (tick && (phase_q == GAP_TC)) begin
                    if (fault_code != '0) begin
                        code_d  = fault_code;
                        pcnt_d  = '0;
                        state_d = ST_CODE_ON;
                    end else begin
                        hb_d    = 1'b0;
                        state_d = ST_HB;
                    end
                end
            end
`ifdef STATUS_LED_ACT_EN
            ST_FLASH_ON: begin
                if (act_pulse) begin
                    restart = 1'b1;
                end else if (tick && (phase_q == FL_TC)) begin
                    state_d = ST_FLASH_OFF;
                end
            end
            ST_FLASH_OFF: begin
                if (tick && (phase_q == FL_TC)) begin
                    hb_d    = 1'b0;
                    state_d = ST_HB;
                end
            end
`endif
            default: begin
                hb_d    = 1'b0;
                state_d = ST_HB;
            end
        endcase

        clr = restart || (state_d != state_q);
        if (clr) begin
            phase_d = '0;
        end

        led_d = 1'b0;
        case (state_d)
            ST_HB:                   led_d = hb_d;
            ST_CODE_ON, ST_FLASH_ON: led_d = 1'b1;
            default:                 led_d = 1'b0;
        endcase
        busy_d = (state_d != ST_HB);
    end

    // Registered one cycle early so code_done lands on the gap's final cycle.
    always_comb begin
        done_d = (state_d == ST_CODE_GAP) && (phase_d == GAP_TC) && tick_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HB;
            phase_q <= '0;
            hb_q    <= 1'b0;
            code_q  <= '0;
            pcnt_q  <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            hb_q    <= hb_d;
            code_q  <= code_d;
            pcnt_q  <= pcnt_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign led       = led_q;
    assign busy      = busy_q;
    assign code_done = done_q;

endmodule

// File: tb/tb_status_led_ctrl.sv
// Directed bench for status_led_ctrl at DIV = 10: segment table of held inputs and expected outputs,
// plus a hand-written reset-during-code sequence. Flash segments depend on STATUS_LED_ACT_EN.
module tb_status_led_ctrl;
    import status_led_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [FAULT_W-1:0] fault_code = '0;
    logic               act_pulse = 1'b0;
    logic               led;
    logic               busy;
    logic               code_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] fault;
        logic       act;
        int         len;
        logic       led;
        logic       busy;
        logic       done_last;
    } seg_t;

    seg_t segs[$];

    always #5 clk = ~clk;

    status_led_ctrl #(
        .CLK_HZ         (100),
        .TICK_HZ        (10),
        .HB_TICKS       (5),
        .CODE_ON_TICKS  (2),
        .CODE_OFF_TICKS (3),
        .CODE_GAP_TICKS (8),
        .FLASH_TICKS    (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fault_code (fault_code),
        .act_pulse  (act_pulse),
        .led        (led),
        .busy       (busy),
        .code_done  (code_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] f, input logic a, input int n,
                       input logic l, input logic b, input logic d);
        seg_t s;
        s.fault = f; s.act = a; s.len = n; s.led = l; s.busy = b; s.done_last = d;
        segs.push_back(s);
    endtask

    task automatic add_pulses(input logic [3:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            add(f, 0, 20, 1, 1, 0);
            add(f, 0, 30, 0, 1, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        int pulses;
        logic prev_led;
        logic done_seen;

        // heartbeat from reset: rise at 50, fall at 100, rise at 150
        add(0, 0, 49, 0, 0, 0);
        add(0, 0, 50, 1, 0, 0);
        add(0, 0, 50, 0, 0, 0);
        add(0, 0, 1,  1, 0, 0);
        // code 3 held
        add_pulses(3, 3);
        add(3, 0, 80, 0, 1, 1);
        // 3 -> 5 during the second pulse: this burst stays at 3, next one is 5
        add_pulses(3, 1);
        add(3, 0, 10, 1, 1, 0);
        add(5, 0, 10, 1, 1, 0);
        add(5, 0, 30, 0, 1, 0);
        add_pulses(5, 1);
        add(5, 0, 80, 0, 1, 1);
        add_pulses(5, 5);
        // fault clears mid-gap: back to heartbeat with led low
        add(5, 0, 40, 0, 1, 0);
        add(0, 0, 40, 0, 1, 1);
        add(0, 0, 50, 0, 0, 0);
        add(0, 0, 50, 1, 0, 0);
`ifdef STATUS_LED_ACT_EN
        add(0, 1, 10, 1, 1, 0);
        add(0, 0, 10, 0, 1, 0);
        add(0, 0, 50, 0, 0, 0);
        add(0, 0, 10, 1, 0, 0);
`else
        add(0, 1, 50, 0, 0, 0);
        add(0, 0, 10, 1, 0, 0);
`endif
        // act and fault 2 together: fault wins, no flash
        add(2, 1, 20, 1, 1, 0);
        add(2, 0, 30, 0, 1, 0);
        add(2, 0, 20, 1, 1, 0);
        add(0, 0, 30, 0, 1, 0);
        add(0, 0, 80, 0, 1, 1);
        add(0, 0, 50, 0, 0, 0);
        add(0, 0, 1,  1, 0, 0);
`ifdef STATUS_LED_ACT_EN
        // flash restart, act dropped in FLASH_OFF, fault during flash taken at next HB cycle
        add(0, 1, 5,  1, 1, 0);
        add(0, 1, 10, 1, 1, 0);
        add(0, 0, 1,  0, 1, 0);
        add(0, 1, 4,  0, 1, 0);
        add(1, 0, 5,  0, 1, 0);
        add(1, 0, 1,  0, 0, 0);
        add(1, 0, 20, 1, 1, 0);
        add(1, 0, 30, 0, 1, 0);
        add(0, 0, 80, 0, 1, 1);
        add(0, 0, 50, 0, 0, 0);
`endif

        reset = 1'b1;
        repeat (3) step();
        chk_bit("reset led", led, 1'b0);
        chk_bit("reset busy", busy, 1'b0);
        chk_bit("reset code_done", code_done, 1'b0);

        reset = 1'b0;
        chk_bit("release led", led, 1'b0);

        for (int k = 0; k < segs.size(); k++) begin
            fault_code = segs[k].fault;
            act_pulse  = segs[k].act;
            for (int i = 0; i < segs[k].len; i++) begin
                step();
                act_pulse = 1'b0;
                chk_bit($sformatf("seg%0d.%0d led", k, i), led, segs[k].led);
                chk_bit($sformatf("seg%0d.%0d busy", k, i), busy, segs[k].busy);
                chk_bit($sformatf("seg%0d.%0d code_done", k, i), code_done,
                        segs[k].done_last && (i == segs[k].len - 1));
            end
        end

        // reset in the middle of CODE_ON abandons the code; it restarts from pulse 1
        fault_code = 4'd4;
        step();
        chk_bit("pre-reset led", led, 1'b1);
        chk_bit("pre-reset busy", busy, 1'b1);
        repeat (9) step();
        reset = 1'b1;
        step();
        chk_bit("mid-code reset led", led, 1'b0);
        chk_bit("mid-code reset busy", busy, 1'b0);
        chk_bit("mid-code reset code_done", code_done, 1'b0);
        step();
        reset = 1'b0;
        cycles = 0;
        pulses = 0;
        prev_led = led;
        done_seen = 1'b0;
        while (cycles < 1000 && !done_seen) begin
            step();
            cycles++;
            if (cycles == 1) begin
                chk_bit("restart first led", led, 1'b1);
                chk_bit("restart first busy", busy, 1'b1);
            end
            if (led && !prev_led) pulses++;
            prev_led = led;
            if (code_done) done_seen = 1'b1;
        end
        chk_bit("restart code_done seen", done_seen, 1'b1);
        chk_int("restart code length", cycles, 280);
        chk_int("restart pulse count", pulses, 4);
        fault_code = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
